// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL      = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL      = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
  localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

  // Half-open window test [lo, hi) used for the sync pulse decodes.
  function automatic logic in_window(input coord_t pos, input coord_t lo, input coord_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..tc_i when enabled and wraps to 0.
// cnt_nxt_o exposes the value the counter will hold after the next edge so
// the parent can register its decodes in step with the count.
module vga_axis_counter
  import vga_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   en_i,
  input  coord_t tc_i,
  output coord_t cnt_o,
  output coord_t cnt_nxt_o,
  output logic   wrap_o
);

  coord_t cnt_q, cnt_d;

  assign wrap_o    = en_i && (cnt_q == tc_i);
  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;

  // Next count: wrap at terminal count, otherwise advance when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 10'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, registered blank/sync
// and line/frame pulses, completed-frame counter.
// Optional build macro VGA_PIPE_ALIGN_EN delays hs/vs by one cycle so they
// line up with RGB that downstream renderers register one cycle late.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
)(
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam coord_t H_LAST    = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_LAST    = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t H_VIS_END = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_END = coord_t'(V_VISIBLE);
  localparam coord_t HS_START  = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END    = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_START  = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END    = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t hc, hc_nxt, vc, vc_nxt;
  logic   h_wrap, v_wrap;

  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_q, blank_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_count_q, frame_count_d;

  vga_axis_counter u_hcnt (
    .clk_i     (vga_clk),
    .rst_i     (reset),
    .en_i      (1'b1),
    .tc_i      (H_LAST),
    .cnt_o     (hc),
    .cnt_nxt_o (hc_nxt),
    .wrap_o    (h_wrap)
  );

  vga_axis_counter u_vcnt (
    .clk_i     (vga_clk),
    .rst_i     (reset),
    .en_i      (h_wrap),
    .tc_i      (V_LAST),
    .cnt_o     (vc),
    .cnt_nxt_o (vc_nxt),
    .wrap_o    (v_wrap)
  );

  // Decode the upcoming position so registered outputs match DrawX/DrawY.
  always_comb begin
    hs_d          = ~in_window(hc_nxt, HS_START, HS_END);
    vs_d          = ~in_window(vc_nxt, VS_START, VS_END);
    blank_d       = (hc_nxt < H_VIS_END) && (vc_nxt < V_VIS_END);
    line_start_d  = (hc_nxt == '0);
    frame_start_d = (hc_nxt == '0) && (vc_nxt == '0);
    frame_count_d = frame_count_q;
    if (v_wrap) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  // Output registers; reset parks sync inactive and suppresses pulses.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

`ifdef VGA_PIPE_ALIGN_EN
  logic hs_pipe_q, vs_pipe_q;

  // Extra sync stage to match the renderers' one-cycle RGB latency.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_pipe_q <= 1'b1;
      vs_pipe_q <= 1'b1;
    end else begin
      hs_pipe_q <= hs_q;
      vs_pipe_q <= vs_q;
    end
  end

  assign hs = hs_pipe_q;
  assign vs = vs_pipe_q;
`else
  assign hs = hs_q;
  assign vs = vs_q;
`endif

  assign DrawX       = hc;
  assign DrawY       = vc;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule
